bm_pack: RTL and testbench

- Downstream consumer of the bm byte buffer (pack_top).
- Pops bytes from the buffer through its bm_req/bm_q read port and frames them into fixed-length packets: 2-byte sync, sequence, length, payload, checksum.
- Emits packets as a byte stream with valid/ready handshake toward the link-side packet mux.
- Tracks buffer fill itself by counting the bm_vld word strobes that feed the buffer.

---
 rtl/bm_pack.sv | 145 ++++++++++++++
 tb/tb_bm_pack.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bm_pack.sv
// Byte-buffer consumer: pops payload bytes and frames them as
// sync(EB 90) / seq / len / payload / checksum over a valid/ready byte stream.
module bm_pack #(
    parameter int PAY_LEN = 64,
    parameter int RD_LAT  = 1,
    parameter int CRD_DLY = 6
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        bm_vld,
    input  logic [7:0]  bm_q,
    output logic        bm_req,
    output logic [7:0]  pk_data,
    output logic        pk_vld,
    output logic        pk_sop,
    output logic        pk_eop,
    input  logic        pk_rdy,
    output logic [15:0] pkt_cnt,
    output logic        ovf
);
    typedef enum logic [2:0] {IDLE, SYN0, SYN1, SEQ, LEN, FETCH, PAY, CKS} state_t;

    localparam logic [7:0]    LEN8    = 8'(PAY_LEN);
    localparam int            GW      = $clog2(RD_LAT + 2);
    localparam logic [GW-1:0] GAP_MAX = GW'(RD_LAT + 1);

    state_t               state, state_n;
    logic [7:0]           data_n, cks, cks_n, seq, seq_n, pay_cnt, pay_n;
    logic                 vld_n, sop_n, eop_n;
    logic [15:0]          cnt_n, avail;
    logic [16:0]          avail_add;
    logic                 crd_ovf, accept;
    logic [CRD_DLY-1:0]   crd_sr;
    logic [GW-1:0]        gap;

    // Written bytes become poppable CRD_DLY cycles after their word strobe.
    assign avail_add = {1'b0, avail} + (crd_sr[CRD_DLY-1] ? 17'd4 : 17'd0);
    assign crd_ovf   = avail_add > 17'd32768;
    assign accept    = pk_vld && pk_rdy;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pk_data <= 8'h00;
            pk_vld  <= 1'b0;
            pk_sop  <= 1'b0;
            pk_eop  <= 1'b0;
            pkt_cnt <= 16'h0000;
            ovf     <= 1'b0;
            seq     <= 8'h00;
            cks     <= 8'h00;
            pay_cnt <= 8'h00;
            avail   <= 16'h0000;
            crd_sr  <= '0;
            gap     <= GAP_MAX;
        end else begin
            state   <= state_n;
            pk_data <= data_n;
            pk_vld  <= vld_n;
            pk_sop  <= sop_n;
            pk_eop  <= eop_n;
            pkt_cnt <= cnt_n;
            seq     <= seq_n;
            cks     <= cks_n;
            pay_cnt <= pay_n;
            crd_sr  <= {crd_sr[CRD_DLY-2:0], bm_vld};
            if (crd_ovf)
                ovf <= 1'b1;
            avail <= (crd_ovf ? 16'h8000 : avail_add[15:0]) - {15'd0, bm_req};
            if (bm_req)
                gap <= GW'(1);
            else if (gap != GAP_MAX)
                gap <= gap + GW'(1);
        end
    end

    // Next-state and next-output; outputs only change on accept, so they hold while stalled.
    always_comb begin
        state_n = state;
        data_n  = pk_data;
        vld_n   = pk_vld;
        sop_n   = pk_sop;
        eop_n   = pk_eop;
        cks_n   = cks;
        seq_n   = seq;
        pay_n   = pay_cnt;
        cnt_n   = pkt_cnt;
        bm_req  = 1'b0;
        case (state)
            IDLE: if (avail >= 16'(PAY_LEN)) begin
                state_n = SYN0;
                data_n  = 8'hEB;
                vld_n   = 1'b1;
                sop_n   = 1'b1;
                eop_n   = 1'b0;
            end
            SYN0: if (accept) begin
                state_n = SYN1;
                data_n  = 8'h90;
                sop_n   = 1'b0;
            end
            SYN1: if (accept) begin
                state_n = SEQ;
                data_n  = seq;
                cks_n   = seq;
            end
            SEQ: if (accept) begin
                state_n = LEN;
                data_n  = LEN8;
                cks_n   = cks + LEN8;
            end
            LEN: if (accept) begin
                state_n = FETCH;
                vld_n   = 1'b0;
                pay_n   = 8'h00;
            end
            FETCH: if (gap >= GAP_MAX) begin
                bm_req  = 1'b1;
                state_n = PAY;
                data_n  = bm_q;
                vld_n   = 1'b1;
                cks_n   = cks + bm_q;
                pay_n   = pay_cnt + 8'd1;
            end
            PAY: if (accept) begin
                if (pay_cnt < LEN8) begin
                    state_n = FETCH;
                    vld_n   = 1'b0;
                end else begin
                    state_n = CKS;
                    data_n  = cks;
                    eop_n   = 1'b1;
                end
            end
            CKS: if (accept) begin
                state_n = IDLE;
                vld_n   = 1'b0;
                eop_n   = 1'b0;
                cnt_n   = pkt_cnt + 16'd1;
                seq_n   = seq + 8'd1;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_bm_pack.sv
// Directed bench for bm_pack: byte-buffer model on the read port, stream
// collector with hold/ordering monitor, table and packet-model comparisons.
module tb_bm_pack;
    localparam int PAY_LEN = 8;
    localparam int RD_LAT  = 1;
    localparam int CRD_DLY = 6;

    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } vec_t;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        bm_vld = 1'b0;
    logic        pk_rdy = 1'b0;
    logic [7:0]  bm_q;
    logic        bm_req, pk_vld, pk_sop, pk_eop, ovf;
    logic [7:0]  pk_data;
    logic [15:0] pkt_cnt;

    bm_pack #(.PAY_LEN(PAY_LEN), .RD_LAT(RD_LAT), .CRD_DLY(CRD_DLY)) dut (
        .clk_sys(clk_sys), .rst(rst), .bm_vld(bm_vld), .bm_q(bm_q),
        .bm_req(bm_req), .pk_data(pk_data), .pk_vld(pk_vld), .pk_sop(pk_sop),
        .pk_eop(pk_eop), .pk_rdy(pk_rdy), .pkt_cnt(pkt_cnt), .ovf(ovf)
    );

    always #5 clk_sys = ~clk_sys;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Buffer model: every byte ever written, plus a read pointer advanced by pops.
    logic [7:0] mem[$];
    int         rd_ptr = 0;
    logic       req_seen = 1'b0;

    always @(posedge clk_sys) begin
        if (rst) begin
            rd_ptr <= mem.size();
            bm_q   <= 8'h00;
        end else begin
            rd_ptr <= rd_ptr + (req_seen ? 1 : 0);
            bm_q   <= (rd_ptr + (req_seen ? 1 : 0) < mem.size()) ?
                      mem[rd_ptr + (req_seen ? 1 : 0)] : 8'h00;
        end
    end

    // Stream collector and hold / pop-while-valid monitor.
    vec_t       rx_q[$];
    int         req_cnt = 0, mon_err = 0, hold_cnt = 0;
    logic       prev_vld = 1'b0, prev_rdy = 1'b0, prev_sop = 1'b0, prev_eop = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk_sys) begin
        req_seen <= bm_req;
        if (rst) begin
            prev_vld <= 1'b0;
        end else begin
            if (bm_req)
                req_cnt <= req_cnt + 1;
            if (bm_req && pk_vld)
                mon_err <= mon_err + 1;
            if (prev_vld && !prev_rdy) begin
                hold_cnt <= hold_cnt + 1;
                if ({pk_vld, pk_data, pk_sop, pk_eop} !== {1'b1, prev_data, prev_sop, prev_eop})
                    mon_err <= mon_err + 1;
            end
            if (pk_vld && pk_rdy)
                rx_q.push_back(vec_t'{pk_data, pk_sop, pk_eop});
            prev_vld  <= pk_vld;
            prev_rdy  <= pk_rdy;
            prev_data <= pk_data;
            prev_sop  <= pk_sop;
            prev_eop  <= pk_eop;
        end
    end

    int rx_base, req_base, mem_base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        bm_vld = 1'b0;
        pk_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rx_base  = rx_q.size();
        req_base = req_cnt;
        mem_base = mem.size();
    endtask

    task automatic send_word(input logic [31:0] w);
        bm_vld = 1'b1;
        mem.push_back(w[31:24]);
        mem.push_back(w[23:16]);
        mem.push_back(w[15:8]);
        mem.push_back(w[7:0]);
        tick();
        bm_vld = 1'b0;
    endtask

    task automatic wait_cnt(input int target, input bit rnd, input int budget);
        int i = 0;
        while (pkt_cnt != 16'(target) && i < budget) begin
            pk_rdy = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
            tick();
            i++;
        end
        pk_rdy = 1'b1;
        chk("pkt_wait", 32'(pkt_cnt), 32'(16'(target)));
    endtask

    task automatic chk_rx(input string tag, input int idx, input logic [7:0] d,
                          input logic s, input logic e);
        logic [31:0] act;
        act = (idx < rx_q.size()) ? {22'd0, rx_q[idx].data, rx_q[idx].sop, rx_q[idx].eop}
                                  : 32'hFFFF_FFFF;
        chk($sformatf("%s[%0d]", tag, idx - rx_base), act, {22'd0, d, s, e});
    endtask

    // Packet reference: EB 90 seq len payload cks, cks = seq + len + payload (mod 256).
    task automatic check_pkt(input string tag, input int ri, input logic [7:0] sq, input int mo);
        logic [7:0] c;
        c = sq + 8'(PAY_LEN);
        chk_rx(tag, ri,     8'hEB, 1'b1, 1'b0);
        chk_rx(tag, ri + 1, 8'h90, 1'b0, 1'b0);
        chk_rx(tag, ri + 2, sq, 1'b0, 1'b0);
        chk_rx(tag, ri + 3, 8'(PAY_LEN), 1'b0, 1'b0);
        for (int k = 0; k < PAY_LEN; k++) begin
            c = c + mem[mo + k];
            chk_rx(tag, ri + 4 + k, mem[mo + k], 1'b0, 1'b0);
        end
        chk_rx(tag, ri + 4 + PAY_LEN, c, 1'b0, 1'b1);
    endtask

    vec_t        tbl[13];
    logic [31:0] words[2];

    initial begin
        int bad, seen, i;
        words = '{32'h0102_0304, 32'h0506_0708};
        // cks = 00 + 08 + (01+..+08 = 24h) = 2Ch
        tbl = '{'{8'hEB, 1'b1, 1'b0}, '{8'h90, 1'b0, 1'b0}, '{8'h00, 1'b0, 1'b0},
                '{8'h08, 1'b0, 1'b0}, '{8'h01, 1'b0, 1'b0}, '{8'h02, 1'b0, 1'b0},
                '{8'h03, 1'b0, 1'b0}, '{8'h04, 1'b0, 1'b0}, '{8'h05, 1'b0, 1'b0},
                '{8'h06, 1'b0, 1'b0}, '{8'h07, 1'b0, 1'b0}, '{8'h08, 1'b0, 1'b0},
                '{8'h2C, 1'b0, 1'b1}};

        // Reset state and idle quiet period.
        do_reset();
        chk("rst_pk_data", 32'(pk_data), 0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
        chk("rst_sop_eop", {30'd0, pk_sop, pk_eop}, 0);
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            if (bm_req || pk_vld || ovf)
                bad++;
            tick();
        end
        chk("idle_quiet", 32'(bad), 0);
        chk("idle_avail", 32'(dut.avail), 0);

        // One packet, sink always ready.
        do_reset();
        pk_rdy = 1'b1;
        for (int w = 0; w < 2; w++)
            send_word(words[w]);
        wait_cnt(1, 1'b0, 500);
        repeat (4) tick();
        chk("t2_len", 32'(rx_q.size() - rx_base), 13);
        for (int k = 0; k < 13; k++)
            chk_rx("t2", rx_base + k, tbl[k].data, tbl[k].sop, tbl[k].eop);
        chk("t2_reqs", 32'(req_cnt - req_base), 8);
        chk("t2_pkt_cnt", 32'(pkt_cnt), 1);

        // Same packet with a 30% ready duty cycle.
        do_reset();
        for (int w = 0; w < 2; w++)
            send_word(words[w]);
        wait_cnt(1, 1'b1, 3000);
        repeat (4) tick();
        chk("t3_len", 32'(rx_q.size() - rx_base), 13);
        for (int k = 0; k < 13; k++)
            chk_rx("t3", rx_base + k, tbl[k].data, tbl[k].sop, tbl[k].eop);
        chk("t3_reqs", 32'(req_cnt - req_base), 8);
        chk("t3_holds_seen", 32'(hold_cnt > 0), 1);

        // Insufficient credit holds off the packet; one more word releases it.
        do_reset();
        pk_rdy = 1'b1;
        send_word(32'h1122_3344);
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            if (pk_vld)
                seen++;
            tick();
        end
        chk("t4_no_pkt", 32'(seen), 0);
        chk("t4_avail4", 32'(dut.avail), 4);
        send_word(32'h5566_7788);
        wait_cnt(1, 1'b0, 500);
        repeat (4) tick();
        check_pkt("t4", rx_base, 8'h00, mem_base);
        chk("t4_avail_end", 32'(dut.avail), 0);

        // 256 back-to-back packets: seq wraps, every checksum modelled.
        do_reset();
        pk_rdy = 1'b1;
        for (int w = 0; w < 256 * PAY_LEN / 4; w++)
            send_word({8'(4*w), 8'(4*w + 1), 8'(4*w + 2), 8'(4*w + 3)});
        wait_cnt(256, 1'b0, 20000);
        repeat (4) tick();
        for (int p = 0; p < 256; p++)
            check_pkt("t5", rx_base + p * (PAY_LEN + 5), 8'(p), mem_base + p * PAY_LEN);
        chk("t5_seq_wrap", 32'(dut.seq), 0);

        // Credit saturation boundary, sticky ovf, then reset mid-payload.
        do_reset();
        pk_rdy = 1'b0;
        for (int w = 0; w < 8192; w++)
            send_word(32'(w));
        repeat (CRD_DLY + 2) tick();
        chk("t6_ovf_at_max", 32'(ovf), 0);
        chk("t6_avail_max", 32'(dut.avail), 32768);
        send_word(32'hA5A5_A5A5);
        repeat (CRD_DLY + 2) tick();
        chk("t6_ovf_set", 32'(ovf), 1);
        chk("t6_avail_sat", 32'(dut.avail), 32768);
        repeat (20) tick();
        chk("t6_ovf_sticky", 32'(ovf), 1);
        pk_rdy = 1'b1;
        i = 0;
        while (rx_q.size() - rx_base < 6 && i < 200) begin
            tick();
            i++;
        end
        chk("t6_in_payload", 32'(rx_q.size() - rx_base >= 6), 1);
        #2 rst = 1'b1;
        tick();
        chk("t6_rst_vld", 32'(pk_vld), 0);
        chk("t6_rst_data", 32'(pk_data), 0);
        chk("t6_rst_sop", 32'(pk_sop), 0);
        chk("t6_rst_eop", 32'(pk_eop), 0);
        chk("t6_rst_req", 32'(bm_req), 0);
        chk("t6_rst_cnt", 32'(pkt_cnt), 0);
        chk("t6_rst_ovf", 32'(ovf), 0);
        rst = 1'b0;
        tick();

        chk("monitor_hold_and_pop", 32'(mon_err), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
